fetch_stage: RTL

Instruction-fetch stage of the pipelined hart, directly upstream of decode. It owns the program counter and drives the instruction-memory read port. It registers the fetched word into the fetch/decode (F/D) pipeline register and accepts stall, flush, redirect (branch/jump resolution) and halt requests from downstream stages. It also signals misaligned redirect targets as a trap.

---
 rtl/fetch_stage.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives the imem read port
// and registers the fetched word into the fetch/decode (F/D) pipeline register.
// Latency: imem word at o_imem_raddr in cycle N appears on o_fd_* in cycle N+1.
// Backpressure: i_stall freezes PC and F/D. Redirect, flush and halt take
// priority over stall.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the o_fetch_count and
// o_stall_count performance counters. Without it those ports are absent.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   o_imem_raddr          imem read address (= pc_q, always word aligned)
//   i_imem_rdata          imem word, combinationally valid in the same cycle
//   i_stall / i_flush     decode backpressure / invalidate F/D
//   i_redirect_valid/_pc  resolved taken branch/jump and its target
//   i_halt                ebreak retired, stop fetching
//   o_fd_*                F/D register: valid, inst, pc, pc+4, trap
//   o_halted              fetch stage is in HALT
//   o_fetch_count/o_stall_count  (FETCH_PERF_CNT_EN only) saturating counters

module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_fd_valid,
  output logic [31:0] o_fd_inst,
  output logic [31:0] o_fd_pc,
  output logic [31:0] o_fd_pc4,
  output logic        o_fd_trap,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_stall_count,
`endif
  output logic        o_halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_inst_q, fd_inst_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_pc4_q, fd_pc4_d;
  logic        fd_trap_q, fd_trap_d;
  logic        halted_q;

  logic [31:0] pc_plus4;
  logic        redirect_aligned;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = (i_redirect_pc[1:0] == 2'b00);

  // Next-state and next F/D contents. Invalidating F/D clears valid, inst and
  // trap; the pc/pc4 fields keep their old values since nothing consumes them
  // while valid is low.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fd_valid_d = fd_valid_q;
    fd_inst_d  = fd_inst_q;
    fd_pc_d    = fd_pc_q;
    fd_pc4_d   = fd_pc4_q;
    fd_trap_d  = fd_trap_q;

    case (state_q)
      BOOT: begin
        // One idle cycle with pc_q = RESET_ADDR before the first fetch.
        state_d = i_halt ? HALT : RUN;
      end

      RUN: begin
        if (i_halt) begin
          state_d    = HALT;
          fd_valid_d = 1'b0;
          fd_inst_d  = NOP_INST;
          fd_trap_d  = 1'b0;
        end else if (i_redirect_valid) begin
          if (redirect_aligned) begin
            // Stall is deliberately ignored: the word in F/D is wrong-path.
            pc_d       = i_redirect_pc;
            fd_valid_d = 1'b0;
            fd_inst_d  = NOP_INST;
            fd_trap_d  = 1'b0;
          end else begin
            // Misaligned target: hand a trap marker to decode carrying the
            // unaligned address, then stop fetching.
            pc_d       = {i_redirect_pc[31:2], 2'b00};
            fd_valid_d = 1'b1;
            fd_inst_d  = NOP_INST;
            fd_pc_d    = i_redirect_pc;
            fd_pc4_d   = i_redirect_pc + 32'd4;
            fd_trap_d  = 1'b1;
            state_d    = HALT;
          end
        end else if (i_flush) begin
          pc_d       = pc_plus4;
          fd_valid_d = 1'b0;
          fd_inst_d  = NOP_INST;
          fd_trap_d  = 1'b0;
        end else if (!i_stall) begin
          pc_d       = pc_plus4;
          fd_valid_d = 1'b1;
          fd_inst_d  = i_imem_rdata;
          fd_pc_d    = pc_q;
          fd_pc4_d   = pc_plus4;
          fd_trap_d  = 1'b0;
        end
      end

      HALT: begin
        // Only a pending trap entry can still be valid here; it stays until
        // decode accepts it (one cycle with i_stall low).
        if (fd_valid_q && !i_stall) begin
          fd_valid_d = 1'b0;
          fd_inst_d  = NOP_INST;
          fd_trap_d  = 1'b0;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_ADDR;
      fd_valid_q <= 1'b0;
      fd_inst_q  <= NOP_INST;
      fd_pc_q    <= 32'd0;
      fd_pc4_q   <= 32'd0;
      fd_trap_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fd_valid_q <= fd_valid_d;
      fd_inst_q  <= fd_inst_d;
      fd_pc_q    <= fd_pc_d;
      fd_pc4_q   <= fd_pc4_d;
      fd_trap_q  <= fd_trap_d;
      halted_q   <= (state_d == HALT);
    end
  end

  assign o_imem_raddr = pc_q;
  assign o_fd_valid   = fd_valid_q;
  assign o_fd_inst    = fd_inst_q;
  assign o_fd_pc      = fd_pc_q;
  assign o_fd_pc4     = fd_pc4_q;
  assign o_fd_trap    = fd_trap_q;
  assign o_halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic        in_run_plain;
  logic        fetch_inc;
  logic        stall_inc;
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // RUN edge where none of halt/redirect/flush wins.
  assign in_run_plain = (state_q == RUN) && !i_halt && !i_redirect_valid && !i_flush;
  assign fetch_inc    = in_run_plain && !i_stall;
  assign stall_inc    = in_run_plain &&  i_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_fetch_count = fetch_cnt_q;
  assign o_stall_count = stall_cnt_q;
`endif

endmodule
